// File: rtl/decrypter.sv
// rtl/decrypter.sv - 78-bit ciphertext to 60-bit plaintext decrypter with multi-cycle rotate
// Optional parity comparison: define DECRYPTER_PARITY_CHECK_EN.
module decrypter #(
  parameter int ROT_STEP = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [77:0] data_to_be_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [59:0] output_decrypted,
  output logic        parity_err,
  output logic        busy
);

  localparam logic [5:0] STEP = 6'(ROT_STEP);

  typedef enum logic [2:0] {IDLE, XFORM, ROT, CHECK, DONE} state_t;

  state_t      state, state_nxt;
  logic [77:0] word_q;
  logic [59:0] d_q, d_nxt;
  logic [5:0]  rot_cnt, rot_cnt_nxt;

  logic [5:0]   r6;
  logic [10:0]  r11;
  logic [59:0]  c;
  logic [1:0]   mode;
  logic [59:0]  k60;
  logic [59:0]  a60;
  logic [59:0]  xored;
  logic [59:0]  reversed;
  logic [5:0]   rot_init;
  logic [5:0]   step_amt;
  logic [119:0] rot_wide;

  assign r6   = word_q[77:72];
  assign r11  = word_q[71:61];
  assign c    = word_q[59:0];
  assign mode = r6[1:0];
  assign k60  = {r6, r11, r6, r11, r6, r11, r11[8:0]};
  assign a60  = {43'd0, r6, r11};
  assign xored = c ^ k60;

  always_comb begin
    reversed = '0;
    for (int i = 0; i < 60; i++) begin
      reversed[i] = xored[59-i];
    end
  end

  // R6 is 0..63, so a single conditional subtract gives R6 mod 60
  assign rot_init = (r6 >= 6'd60) ? (r6 - 6'd60) : r6;
  assign step_amt = (rot_cnt < STEP) ? rot_cnt : STEP;
  assign rot_wide = {d_q, d_q} >> step_amt;

  always_comb begin
    state_nxt   = state;
    d_nxt       = d_q;
    rot_cnt_nxt = rot_cnt;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = XFORM;
      end
      XFORM: begin
        case (mode)
          2'd0:    d_nxt = xored;
          2'd1:    d_nxt = xored;
          2'd2:    d_nxt = c - a60;
          default: d_nxt = reversed;
        endcase
        rot_cnt_nxt = rot_init;
        state_nxt   = (mode == 2'd1 && rot_init != 6'd0) ? ROT : CHECK;
      end
      ROT: begin
        d_nxt       = rot_wide[59:0];
        rot_cnt_nxt = rot_cnt - step_amt;
        if (rot_cnt == step_amt) state_nxt = CHECK;
      end
      CHECK: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      d_q     <= '0;
      rot_cnt <= '0;
      word_q  <= '0;
    end else begin
      state   <= state_nxt;
      d_q     <= d_nxt;
      rot_cnt <= rot_cnt_nxt;
      if (state == IDLE && in_valid) word_q <= data_to_be_decrypt;
    end
  end

`ifdef DECRYPTER_PARITY_CHECK_EN
  logic parity_err_reg;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      parity_err_reg <= 1'b0;
    end else if (state == CHECK) begin
      parity_err_reg <= (^d_q) != word_q[60];
    end
  end

  assign parity_err = parity_err_reg & (state == DONE);
`else
  // The P bit only feeds the comparison, which is not built here
  logic unused_parity_bit;
  assign unused_parity_bit = word_q[60];
  assign parity_err        = 1'b0;
`endif

  assign in_ready         = (state == IDLE);
  assign busy             = (state != IDLE);
  assign out_valid        = (state == DONE);
  assign output_decrypted = d_q;

endmodule
